// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for the data-memory access unit.
// The master is the CPU MEM stage; the slave is mem_access_unit.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, done, rdata, misalign
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, done, rdata, misalign
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store controller in front of a word-wide RAM.
// Sub-word stores are done as read-modify-write; misaligned accesses abort with done+misalign.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      cpu,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  input  logic [31:0]           ram_dout
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH+1:0] addr_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [1:0]            size_p0;
  logic                  we_p0;
  logic                  sext_p0;
  logic [DATA_W-1:0]     rdata_p1;
  logic [DATA_W-1:0]     merged_p1;
  logic [1:0]            lane;
  logic                  req_misaligned;

  // Byte-address bits above the RAM's reach are deliberately dropped so the address wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu.addr[31:ADDR_WIDTH+2];

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane_sel,
    input logic [1:0]        size,
    input logic              sext
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane_sel, 3'b000} +: 8];
    h = word[{lane_sel[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{24{sext & b[7]}}, b};
      2'b01:   load_extract = {{16{sext & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] wd,
    input logic [1:0]        lane_sel,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] m;
    m = word;
    case (size)
      2'b00:   m[{lane_sel, 3'b000} +: 8]     = wd[7:0];
      2'b01:   m[{lane_sel[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    store_merge = m;
  endfunction

  assign lane           = addr_p0[1:0];
  assign req_misaligned = is_misaligned(cpu.size, cpu.addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu.req) begin
          state_next = req_misaligned ? ERR : READ;
        end
      end
      READ:    state_next = we_p0 ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: request fields captured at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0  <= '0;
      wdata_p0 <= '0;
      size_p0  <= '0;
      we_p0    <= 1'b0;
      sext_p0  <= 1'b0;
    end else if (state == IDLE && cpu.req) begin
      addr_p0  <= cpu.addr[ADDR_WIDTH+1:0];
      wdata_p0 <= cpu.wdata;
      size_p0  <= cpu.size;
      we_p0    <= cpu.we;
      sext_p0  <= cpu.sign_ext;
    end
  end

  // Stage p1: load result or merged store word, computed from the READ-cycle RAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1  <= '0;
      merged_p1 <= '0;
    end else if (state == READ) begin
      if (we_p0) begin
        merged_p1 <= store_merge(ram_dout, wdata_p0, lane, size_p0);
      end else begin
        rdata_p1 <= load_extract(ram_dout, lane, size_p0, sext_p0);
      end
    end
  end

  assign ram_addr     = addr_p0[ADDR_WIDTH+1:2];
  assign ram_din      = merged_p1;
  assign ram_we       = (state == WRITE);
  assign cpu.ready    = (state == IDLE);
  assign cpu.done     = (state == RESP) || (state == ERR);
  assign cpu.misalign = (state == ERR);
  assign cpu.rdata    = rdata_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM and hand-computed expectations.
module tb_mem_access_unit;
  localparam int ADDR_WIDTH = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic                  ram_we;
  logic [31:0]           ram_dout;
  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

  int n_checks = 0;
  int n_errors = 0;

  int                    d_cyc;
  logic                  d_mis;
  logic [31:0]           d_rd;
  int                    we_cnt;
  int                    we_cyc;
  logic [ADDR_WIDTH-1:0] we_addr;
  logic [31:0]           we_data;

  mem_access_unit_if bus();

  mem_access_unit #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: request on an IDLE cycle, then watch up to 8 cycles for ram_we and done.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check("ready_idle", {31'b0, bus.ready}, 32'd1);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 bus.req = 1'b0;
    d_cyc = -1; d_mis = 1'b0; d_rd = 'x; we_cnt = 0; we_cyc = -1; we_addr = '0; we_data = '0;
    for (int c = 1; c <= 8 && d_cyc < 0; c++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cnt++; we_cyc = c; we_addr = ram_addr; we_data = ram_din;
      end
      if (bus.done) begin
        d_cyc = c; d_mis = bus.misalign; d_rd = bus.rdata;
        check("done_with_ready", {31'b0, bus.ready}, 32'd0);
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t loads [6];

  initial begin
    logic [15:0] we_mask, done_mask, rdy_mask;

    loads[0] = '{"lb_13",  2'b00, 1'b1, 32'h13, 32'hFFFFFFDE};
    loads[1] = '{"lbu_13", 2'b00, 1'b0, 32'h13, 32'h000000DE};
    loads[2] = '{"lh_10",  2'b01, 1'b1, 32'h10, 32'hFFFFBEEF};
    loads[3] = '{"lhu_12", 2'b01, 1'b0, 32'h12, 32'h0000DEAA};
    loads[4] = '{"lb_10",  2'b00, 1'b1, 32'h10, 32'hFFFFFFEF};
    loads[5] = '{"lw11_10", 2'b11, 1'b0, 32'h10, 32'hDEAABEEF};

    for (int i = 0; i < (1<<ADDR_WIDTH); i++) mem[i] = 32'h0;
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_ready",    {31'b0, bus.ready},    32'd1);
    check("rst_done",     {31'b0, bus.done},     32'd0);
    check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
    check("rst_rdata",    bus.rdata,             32'h0);
    check("rst_ram_we",   {31'b0, ram_we},       32'd0);
    check("rst_ram_addr", {22'b0, ram_addr},     32'h0);
    check("rst_ram_din",  ram_din,               32'h0);
    rst = 1'b0;

    // Word store
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_done_cyc", d_cyc, 32'd3);
    check("sw_we_cnt",   we_cnt, 32'd1);
    check("sw_we_cyc",   we_cyc, 32'd2);
    check("sw_we_addr",  {22'b0, we_addr}, 32'd4);
    check("sw_we_data",  we_data, 32'hDEADBEEF);
    check("sw_mis",      {31'b0, d_mis}, 32'd0);
    check("sw_mem4",     mem[4], 32'hDEADBEEF);

    // Byte store read-modify-write; upper wdata bits must be ignored
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AA);
    check("sb_done_cyc", d_cyc, 32'd3);
    check("sb_we_cnt",   we_cnt, 32'd1);
    check("sb_mem4",     mem[4], 32'hDEAABEEF);

    foreach (loads[i]) begin
      access(1'b0, loads[i].size, loads[i].sx, loads[i].addr, 32'hFFFFFFFF);
      check({loads[i].name, "_rdata"}, d_rd, loads[i].exp);
      check({loads[i].name, "_cyc"},   d_cyc, 32'd2);
      check({loads[i].name, "_we"},    we_cnt, 32'd0);
      check({loads[i].name, "_mis"},   {31'b0, d_mis}, 32'd0);
    end

    // Misaligned word store, then misaligned half load
    access(1'b1, 2'b10, 1'b0, 32'h11, 32'h55555555);
    check("mis_sw_cyc",   d_cyc, 32'd1);
    check("mis_sw_flag",  {31'b0, d_mis}, 32'd1);
    check("mis_sw_we",    we_cnt, 32'd0);
    check("mis_sw_rdata", d_rd, 32'hDEAABEEF);
    check("mis_sw_mem4",  mem[4], 32'hDEAABEEF);
    access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
    check("mis_lh_cyc",   d_cyc, 32'd1);
    check("mis_lh_flag",  {31'b0, d_mis}, 32'd1);
    check("mis_lh_we",    we_cnt, 32'd0);
    check("mis_lh_rdata", d_rd, 32'hDEAABEEF);

    // Reset asserted during the WRITE cycle discards the store
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = 32'h20; bus.wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_we_before", {31'b0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_we_drop", {31'b0, ram_we},    32'd0);
    check("rstw_ready",   {31'b0, bus.ready}, 32'd1);
    check("rstw_done",    {31'b0, bus.done},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_mem8",        mem[8], 32'h0);
    check("rstw_ready_after", {31'b0, bus.ready}, 32'd1);
    check("rstw_done_after",  {31'b0, bus.done},  32'd0);

    // Back-to-back stores with req held high; the second one wraps to word 1
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = 32'h8; bus.wdata = 32'h11112222;
    we_mask = '0; done_mask = '0; rdy_mask = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      if (c == 5) #1 bus.req = 1'b0;
      @(negedge clk);
      if (ram_we)    we_mask[c]   = 1'b1;
      if (bus.done)  done_mask[c] = 1'b1;
      if (bus.ready) rdy_mask[c]  = 1'b1;
      if (c == 6) check("b2b_wrap_addr", {22'b0, ram_addr}, 32'd1);
      if (c == 3) begin
        bus.addr = 32'h1004; bus.wdata = 32'hCAFEF00D;
      end
    end
    check("b2b_we_mask",   {16'b0, we_mask},   32'h0044);
    check("b2b_done_mask", {16'b0, done_mask}, 32'h0088);
    check("b2b_rdy_mask",  {16'b0, rdy_mask},  32'h0110);
    check("b2b_mem2",      mem[2], 32'h11112222);
    check("b2b_mem1",      mem[1], 32'hCAFEF00D);
    check("b2b_mem0",      mem[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
